// File: rtl/pipe_stall_ctrl.sv
// Hazard consumer for the 5-stage miniRV pipeline: stall/flush/redirect steering,
// a one-bubble load-use FSM and a memory-wait watchdog. Optional counters: PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_flag,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
`ifdef PIPE_STALL_PERF_EN
    input  logic             perf_clr,
    output logic [CNT_W-1:0] cnt_cycles,
    output logic [CNT_W-1:0] cnt_lu_bubbles,
    output logic [CNT_W-1:0] cnt_br_flushes,
    output logic [CNT_W-1:0] cnt_mem_wait,
`endif
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic [1:0]       ctrl_state,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic            lu_mask_q, lu_mask_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic p1_busy, p2_branch, p3_bubble, run_en;

    assign p1_busy   = mem_busy;
    assign p2_branch = !mem_busy && ex_br_taken;
    assign p3_bubble = !mem_busy && !ex_br_taken && load_use_flag && !lu_mask_q;
    assign run_en    = !rst;

    // Controls are combinational so they act in the cycle the hazard is seen; rst forces them low.
    assign pc_stall     = run_en && (p1_busy || p3_bubble);
    assign if_id_stall  = run_en && (p1_busy || p3_bubble);
    assign pc_redirect  = run_en && p2_branch;
    assign if_id_flush  = run_en && p2_branch;
    assign id_ex_stall  = run_en && p1_busy;
    assign id_ex_flush  = run_en && (p2_branch || p3_bubble);
    assign ex_mem_stall = run_en && p1_busy;
    assign mem_wb_flush = run_en && p1_busy;

    assign ctrl_state  = state_q;
    assign mem_timeout = mem_timeout_q;

    always_comb begin
        state_d   = ST_RUN;
        lu_mask_d = 1'b0;
        if (p1_busy) begin
            state_d   = ST_MEM_WAIT;
            lu_mask_d = lu_mask_q;
        end else if (p3_bubble) begin
            state_d   = ST_LU_STALL;
            lu_mask_d = 1'b1;
        end
    end

    always_comb begin
        wd_d          = '0;
        mem_timeout_d = mem_timeout_q;
        if (mem_busy) begin
            wd_d = (wd_q == {TO_W{1'b1}}) ? wd_q : wd_q + 1'b1;
            if (wd_d >= TO_LIM) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            lu_mask_q     <= 1'b0;
            wd_q          <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lu_mask_q     <= lu_mask_d;
            wd_q          <= wd_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cyc_q, lu_q, br_q, mw_q;

    assign cnt_cycles     = cyc_q;
    assign cnt_lu_bubbles = lu_q;
    assign cnt_br_flushes = br_q;
    assign cnt_mem_wait   = mw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            lu_q  <= '0;
            br_q  <= '0;
            mw_q  <= '0;
        end else if (perf_clr) begin
            cyc_q <= '0;
            lu_q  <= '0;
            br_q  <= '0;
            mw_q  <= '0;
        end else begin
            if (cyc_q != CNT_MAX)              cyc_q <= cyc_q + 1'b1;
            if (p3_bubble && lu_q != CNT_MAX)  lu_q  <= lu_q + 1'b1;
            if (p2_branch && br_q != CNT_MAX)  br_q  <= br_q + 1'b1;
            if (p1_busy && mw_q != CNT_MAX)    mw_q  <= mw_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized and directed bench for pipe_stall_ctrl against a rule-table model.
module tb_pipe_stall_ctrl;
    localparam int MEM_TO = 4;
    localparam int TO_W   = 8;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst, lu, br, busy;
    logic pc_stall, pc_redirect, if_id_stall, if_id_flush;
    logic id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic [1:0] ctrl_state;
    logic mem_timeout;
`ifdef PIPE_STALL_PERF_EN
    logic perf_clr;
    logic [CNT_W-1:0] cnt_cycles, cnt_lu_bubbles, cnt_br_flushes, cnt_mem_wait;
    int m_cyc, m_lu, m_br, m_mw;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MEM_TIMEOUT(MEM_TO), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .load_use_flag(lu), .ex_br_taken(br), .mem_busy(busy),
`ifdef PIPE_STALL_PERF_EN
        .perf_clr(perf_clr),
        .cnt_cycles(cnt_cycles), .cnt_lu_bubbles(cnt_lu_bubbles),
        .cnt_br_flushes(cnt_br_flushes), .cnt_mem_wait(cnt_mem_wait),
`endif
        .pc_stall(pc_stall), .pc_redirect(pc_redirect),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
        .ctrl_state(ctrl_state), .mem_timeout(mem_timeout)
    );

    // {pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    logic [7:0] dut_vec;
    assign dut_vec = {pc_stall, pc_redirect, if_id_stall, if_id_flush,
                      id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    int vectors = 0;
    int miscompares = 0;

    bit m_mask;
    int m_wd;
    bit m_to;
    int m_state;

    function automatic logic [7:0] exp_ctrl(input bit l, input bit b, input bit m, input bit mask);
        if (m)               return 8'b1010_1011;
        else if (b)          return 8'b0101_0100;
        else if (l && !mask) return 8'b1010_0100;
        else                 return 8'b0000_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = 0; m_wd = 0; m_to = 0; m_state = 0;
`ifdef PIPE_STALL_PERF_EN
        m_cyc = 0; m_lu = 0; m_br = 0; m_mw = 0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; lu = 0; br = 0; busy = 0;
`ifdef PIPE_STALL_PERF_EN
        perf_clr = 0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge; applies one cycle of inputs, compares, then advances to the next negedge.
    task automatic step(input bit l, input bit b, input bit m, input bit clr = 0,
                        input bit lit_en = 0, input logic [7:0] lit_v = 8'h00,
                        input logic [1:0] lit_s = 2'd0);
        logic [7:0] ev;
        lu = l; br = b; busy = m;
`ifdef PIPE_STALL_PERF_EN
        perf_clr = clr;
`endif
        #1;
        ev = exp_ctrl(l, b, m, m_mask);
        check("ctrl", dut_vec, ev);
        check("state", ctrl_state, m_state);
        check("timeout", mem_timeout, m_to);
`ifdef PIPE_STALL_PERF_EN
        check("cnt_cycles", cnt_cycles, m_cyc);
        check("cnt_lu", cnt_lu_bubbles, m_lu);
        check("cnt_br", cnt_br_flushes, m_br);
        check("cnt_mw", cnt_mem_wait, m_mw);
`endif
        if (lit_en) begin
            check("lit_ctrl", dut_vec, lit_v);
            check("lit_model", ev, lit_v);
            check("lit_state", ctrl_state, lit_s);
        end
        @(posedge clk);
`ifdef PIPE_STALL_PERF_EN
        if (clr) begin
            m_cyc = 0; m_lu = 0; m_br = 0; m_mw = 0;
        end else begin
            m_cyc++;
            if (m) m_mw++;
            else if (b) m_br++;
            else if (l && !m_mask) m_lu++;
        end
`endif
        if (m) begin
            m_state = 2;
            m_wd = (m_wd >= 255) ? 255 : m_wd + 1;
            if (m_wd >= MEM_TO) m_to = 1;
        end else begin
            m_wd = 0;
            if (!b && l && !m_mask) begin
                m_state = 1; m_mask = 1;
            end else begin
                m_state = 0; m_mask = 0;
            end
        end
`ifndef PIPE_STALL_PERF_EN
        if (clr) m_wd = m_wd;
`endif
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; lu = 0; br = 0; busy = 0;
`ifdef PIPE_STALL_PERF_EN
        perf_clr = 0;
`endif
        model_reset();
        @(negedge clk);
        #1;
        check("rst_outputs", dut_vec, 8'h00);
        check("rst_state", ctrl_state, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // idle
        step(0, 0, 0, 0, 1, 8'h00, 2'd0);
        // load-use held two cycles: one bubble then masked
        step(1, 0, 0, 0, 1, 8'b1010_0100, 2'd0);
        step(1, 0, 0, 0, 1, 8'h00, 2'd1);
        step(0, 0, 0, 0, 1, 8'h00, 2'd0);
        // branch beats load-use
        step(1, 1, 0, 0, 1, 8'b0101_0100, 2'd0);
        step(0, 0, 0, 0, 1, 8'h00, 2'd0);
        // bubble, 3 busy cycles, mask survives
        step(1, 0, 0, 0, 1, 8'b1010_0100, 2'd0);
        step(1, 0, 1, 0, 1, 8'b1010_1011, 2'd1);
        step(1, 0, 1, 0, 1, 8'b1010_1011, 2'd2);
        step(1, 0, 1, 0, 1, 8'b1010_1011, 2'd2);
        step(1, 0, 0, 0, 1, 8'h00, 2'd2);
        step(0, 0, 0, 0, 1, 8'h00, 2'd0);

        // watchdog: five busy cycles then free
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1);
            check("lit_to_dut", mem_timeout, (i >= 4) ? 1 : 0);
            check("lit_to_model", m_to, (i >= 4) ? 1 : 0);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        check("lit_to_sticky", mem_timeout, 1);

        // reset asserted mid-stall
        lu = 1; busy = 1; #1;
        check("pre_rst_stall", pc_stall, 1);
        rst = 1'b1; #1;
        check("mid_rst_outputs", dut_vec, 8'h00);
        check("mid_rst_state", ctrl_state, 2'd0);
        check("mid_rst_timeout", mem_timeout, 0);
        do_reset();

`ifdef PIPE_STALL_PERF_EN
        step(1, 0, 0); step(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(0, 0, 0);
        check("lit_perf_lu", cnt_lu_bubbles, 2);
        check("lit_perf_br", cnt_br_flushes, 1);
        check("lit_perf_mw", cnt_mem_wait, 3);
        step(0, 0, 0, 1);
        check("lit_clr_cyc", cnt_cycles, 0);
        check("lit_clr_lu", cnt_lu_bubbles, 0);
        check("lit_clr_br", cnt_br_flushes, 0);
        check("lit_clr_mw", cnt_mem_wait, 0);
        step(0, 0, 0);
`endif

        // randomized traffic with periodic resets
        for (int n = 0; n < 3000; n++) begin
            bit rl, rb, rm, rc;
            if (n % 600 == 599) do_reset();
            rm = ($urandom_range(0, 4) == 0);
            rb = ($urandom_range(0, 5) == 0);
            rl = $urandom_range(0, 1) == 1;
            rc = ($urandom_range(0, 199) == 0);
            step(rl, rb, rm, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer end of the hazard interface: takes the ID-stage load-use flag, the EX-stage branch/jump redirect and the data-memory busy indication.
- Drives stall, flush and redirect controls to PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers of the 5-stage miniRV pipeline.
- A small FSM guarantees exactly one bubble per load-use event, including across memory wait periods.
- A watchdog flags runaway memory waits.

Parameters:
- MEM_TIMEOUT, 255: number of consecutive mem_busy cycles after which mem_timeout sets.
- TO_W, 8: width of the wait watchdog counter; must hold MEM_TIMEOUT.
- CNT_W, 32: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_use_flag  in  1  ID instruction reads a register being loaded by the EX instruction.
- ex_br_taken  in  1  EX-stage branch or jump is taken; PC must load the target.
- mem_busy  in  1  data memory is not ready this cycle; the MEM stage must hold.
- pc_stall  out  1  PC holds its value.
- pc_redirect  out  1  PC selects the EX branch target.
- if_id_stall  out  1  IF/ID holds.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_stall  out  1  ID/EX holds.
- id_ex_flush  out  1  ID/EX loads a bubble.
- ex_mem_stall  out  1  EX/MEM holds.
- mem_wb_flush  out  1  MEM/WB loads a bubble.
- ctrl_state  out  2  current FSM state: 0 RUN, 1 LU_STALL, 2 MEM_WAIT.
- mem_timeout  out  1  sticky watchdog error.

Behaviour:
- Control outputs are combinational from the registered state, lu_mask and current inputs; they take effect in the same cycle.
- ctrl_state, lu_mask, the watchdog counter and mem_timeout are registered.
- Reset (async):
  - state=RUN, lu_mask=0, watchdog=0, mem_timeout=0.
  - While rst=1, all stall, flush and redirect outputs are 0.
- Per-cycle priority, highest first:
  - P1, mem_busy=1:
    - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush=1.
    - All other outputs 0; ex_br_taken and load_use_flag are ignored.
    - next state=MEM_WAIT; lu_mask is held.
  - P2, ex_br_taken=1:
    - pc_redirect=1, if_id_flush=1, id_ex_flush=1; load_use_flag is ignored because the ID instruction is squashed.
    - next state=RUN; lu_mask cleared.
  - P3, load_use_flag=1 and lu_mask=0:
    - pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble; MEM-stage forwarding covers the rest).
    - next state=LU_STALL; lu_mask set.
  - P4, otherwise:
    - all outputs 0; next state=RUN; lu_mask cleared.
- lu_mask:
  - Masks load_use_flag for exactly one non-busy cycle after a bubble is inserted.
  - Survives any number of MEM_WAIT cycles.
  - Cleared by the first non-busy cycle that does not insert a bubble.
- A stall and a flush are never asserted on the same register in the same cycle.
- Watchdog:
  - Increments on each mem_busy=1 cycle and saturates at 2^TO_W-1.
  - Clears on mem_busy=0.
  - When the count reaches MEM_TIMEOUT, mem_timeout sets and stays set until rst.
  - Pipeline behaviour is unchanged by a timeout.
- Reset asserted mid-stall: outputs drop to 0 immediately and state returns to RUN.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- When defined, the following ports are added:
  - perf_clr (in, 1): synchronous clear of all four counters, takes priority over increment.
  - cnt_cycles (out, CNT_W): counts every non-reset cycle.
  - cnt_lu_bubbles (out, CNT_W): counts P3 cycles.
  - cnt_br_flushes (out, CNT_W): counts P2 cycles.
  - cnt_mem_wait (out, CNT_W): counts P1 cycles.
- All counters are saturating and reset to 0 on rst.
- When undefined, these ports and their registers are absent and the behaviour is otherwise identical.

Test Plan:
- Reset, then idle inputs -> all outputs 0, ctrl_state=0, mem_timeout=0.
- load_use_flag=1 held for 2 cycles -> cycle 1: pc_stall=if_id_stall=id_ex_flush=1, ctrl_state becomes 1; cycle 2: all outputs 0 (masked), ctrl_state returns to 0.
- ex_br_taken=1 and load_use_flag=1 in the same cycle -> pc_redirect=if_id_flush=id_ex_flush=1, pc_stall=0, next ctrl_state=0.
- Load-use bubble, then mem_busy=1 for 3 cycles, then load_use_flag still 1 -> bubble inserted once; 3 full-freeze cycles with mem_wb_flush=1 and ctrl_state=2; first free cycle has outputs 0 due to the mask.
- MEM_TIMEOUT=4, mem_busy=1 for 5 cycles, then 0 -> mem_timeout rises after the 4th busy cycle and remains 1 after mem_busy drops until rst.
- With PIPE_STALL_PERF_EN: 2 bubbles, 1 branch, 3 busy cycles -> cnt_lu_bubbles=2, cnt_br_flushes=1, cnt_mem_wait=3; pulse perf_clr -> all counters read 0 on the next cycle.
